// File: rtl/div_if.sv
// Handshake and operand bundle between the EX stage and the divider sequencer.
interface div_if #(
    parameter int WIDTH = 32
);
    logic               start_i;
    logic               annul_i;
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               stallreq_o;

    // EX stage side: issues the divide and consumes the result.
    modport master (
        output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, stallreq_o
    );

    // Divider side.
    modport slave (
        input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider sequencer for div/divu in EX.
// Result is {remainder, quotient}; the pipeline is stalled until it is ready.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input logic   clk,
    input logic   rst,
    div_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BY_ZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;        // partial remainder (high half)
    logic [WIDTH-1:0]   r_quot;       // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0]   r_divisor;    // divisor magnitude
    logic               r_sign1;      // dividend sign at start
    logic               r_sign2;      // divisor sign at start
    logic               r_signed;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH:0]     w_shift_rem;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_step_rem;
    logic [WIDTH-1:0]   w_step_quot;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic               w_last_iter;

    // Operand magnitudes: negative signed operands are two's-complement negated.
    assign w_mag1 = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign w_mag2 = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

    // One restoring step: shift {rem,quot} left, trial-subtract the divisor.
    // The 33-bit difference always fits, so its top bit is the sign.
    assign w_shift_rem = {r_rem, r_quot[WIDTH-1]};
    assign w_trial     = w_shift_rem - {1'b0, r_divisor};
    assign w_step_rem  = w_trial[WIDTH] ? w_shift_rem[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_step_quot = {r_quot[WIDTH-2:0], ~w_trial[WIDTH]};
    assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));

    // Sign correction of the final step; -2^31 / -1 wraps to 0x80000000 naturally.
    assign w_quot_fix = (r_signed && (r_sign1 ^ r_sign2)) ? -w_step_quot : w_step_quot;
    assign w_rem_fix  = (r_signed && r_sign1) ? -w_step_rem : w_step_rem;

    assign bus.result_o   = r_result;
    assign bus.ready_o    = r_ready;
    assign bus.stallreq_o = bus.start_i & ~bus.annul_i & (r_state != S_END);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic.
    // NOTE: default assigned first so no path through this block infers a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start_i && !bus.annul_i)
                    w_state_next = (bus.opdata2_i == '0) ? S_BY_ZERO : S_ON;
            end
            S_BY_ZERO: w_state_next = bus.annul_i ? S_IDLE : S_END;
            S_ON: begin
                if (bus.annul_i)        w_state_next = S_IDLE;
                else if (w_last_iter)   w_state_next = S_END;
            end
            S_END: begin
                if (bus.annul_i || !bus.start_i) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, result load and clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_signed  <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_result <= '0;
                    r_ready  <= 1'b0;
                    if (bus.start_i && !bus.annul_i) begin
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_quot    <= w_mag1;
                        r_divisor <= w_mag2;
                        r_sign1   <= bus.opdata1_i[WIDTH-1];
                        r_sign2   <= bus.opdata2_i[WIDTH-1];
                        r_signed  <= bus.signed_div_i;
                    end
                end
                S_BY_ZERO: begin
                    r_result <= '0;
                    r_ready  <= !bus.annul_i;
                end
                S_ON: begin
                    if (bus.annul_i) begin
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end else begin
                        r_rem  <= w_step_rem;
                        r_quot <= w_step_quot;
                        r_cnt  <= r_cnt + 1'b1;
                        if (w_last_iter) begin
                            r_result <= {w_rem_fix, w_quot_fix};
                            r_ready  <= 1'b1;
                        end
                    end
                end
                S_END: begin
                    if (bus.annul_i || !bus.start_i) begin
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end
                end
                default: begin
                    r_result <= '0;
                    r_ready  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: vector table plus multi-cycle corner sequences.
module tb_div_ctrl;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    div_if #(.WIDTH(32)) bus ();

    div_ctrl #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait for ready_o (bounded), checking stallreq_o stays high meanwhile.
    task automatic wait_ready(output int n, output logic stall_ok);
        n = 0;
        stall_ok = 1'b1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (bus.ready_o) break;
            if (!bus.stallreq_o) stall_ok = 1'b0;
        end
    endtask

    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat,
                           input int hold);
        int   n;
        logic stall_ok;
        logic hold_ok;
        @(negedge clk);
        bus.start_i      = 1'b1;
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        #1;
        check({name, " stall_at_start"}, 64'(bus.stallreq_o), 64'd1);
        wait_ready(n, stall_ok);
        check({name, " latency"}, 64'(n), 64'(lat));
        check({name, " result"}, bus.result_o, exp);
        check({name, " stall_before_end"}, 64'(stall_ok), 64'd1);
        check({name, " stall_in_end"}, 64'(bus.stallreq_o), 64'd0);
        if (hold > 0) begin
            hold_ok = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (!bus.ready_o || bus.result_o !== exp || bus.stallreq_o) hold_ok = 1'b0;
            end
            check({name, " hold_in_end"}, 64'(hold_ok), 64'd1);
        end
        bus.start_i = 1'b0;
        @(negedge clk);
        check({name, " ready_clear"}, 64'(bus.ready_o), 64'd0);
        check({name, " result_clear"}, bus.result_o, 64'd0);
    endtask

    initial begin
        int   n;
        logic stall_ok;
        logic quiet;

        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{"divu_100_7",     1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33};
        vecs[1]  = '{"div_m7_2",       1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2]  = '{"div_7_m2",       1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33};
        vecs[3]  = '{"div_min_m1",     1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 33};
        vecs[4]  = '{"divu_max_1",     1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 33};
        vecs[5]  = '{"div_by_zero",    1'b1, 32'd0,          32'd0,        64'h0,                 2};
        vecs[6]  = '{"divu_by_zero",   1'b0, 32'd5,          32'd0,        64'h0,                 2};
        vecs[7]  = '{"div_m100_m7",    1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33};
        vecs[8]  = '{"divu_min_max",   1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 33};
        vecs[9]  = '{"divu_max_max",   1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'h00000000_00000001, 33};
        vecs[10] = '{"divu_3_16",      1'b0, 32'd3,          32'h10,       64'h00000003_00000000, 33};
        vecs[11] = '{"divu_m7_2",      1'b0, 32'hFFFFFFF9,   32'd2,        64'h00000001_7FFFFFFC, 33};
        vecs[12] = '{"divu_1e6_1000",  1'b0, 32'd1000000,    32'd1000,     64'h00000000_000003E8, 33};
        vecs[13] = '{"divu_hex",       1'b0, 32'h12345678,   32'h1000,     64'h00000678_00012345, 33};

        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        repeat (3) @(negedge clk);
        check("reset ready", 64'(bus.ready_o), 64'd0);
        check("reset result", bus.result_o, 64'd0);
        check("reset stall", 64'(bus.stallreq_o), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0);

        // Hold start in END for 5 extra cycles: no restart, result stable.
        run_div("hold_end", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 5);

        // Operands changed mid-ON are ignored.
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
        repeat (5) @(negedge clk);
        bus.signed_div_i = 1'b1; bus.opdata1_i = 32'hFFFFFFFF; bus.opdata2_i = 32'd3;
        wait_ready(n, stall_ok);
        check("mid_change latency", 64'(n), 64'd28);
        check("mid_change result", bus.result_o, 64'h00000002_0000000E);
        bus.start_i = 1'b0;
        @(negedge clk);
        check("mid_change clear", 64'(bus.ready_o), 64'd0);

        // Annul at iteration 10: stall drops at once, IDLE next, ready never rises.
        @(negedge clk);
        bus.start_i = 1'b1; bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
        repeat (11) @(negedge clk);
        bus.annul_i = 1'b1;
        #1;
        check("annul_on stall", 64'(bus.stallreq_o), 64'd0);
        @(negedge clk);
        bus.annul_i = 1'b0; bus.start_i = 1'b0;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o || bus.result_o != 64'd0) quiet = 1'b0;
        end
        check("annul_on no_ready", 64'(quiet), 64'd1);
        run_div("after_annul", 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 33, 0);

        // Annul in IDLE blocks the start.
        @(negedge clk);
        bus.start_i = 1'b1; bus.annul_i = 1'b1;
        bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
        #1;
        check("annul_idle stall", 64'(bus.stallreq_o), 64'd0);
        repeat (3) @(negedge clk);
        bus.annul_i = 1'b0;
        wait_ready(n, stall_ok);
        check("annul_idle latency", 64'(n), 64'd33);
        check("annul_idle result", bus.result_o, 64'h00000002_0000000E);

        // Annul in END with start still held: clears to IDLE.
        bus.annul_i = 1'b1;
        @(negedge clk);
        check("annul_end ready", 64'(bus.ready_o), 64'd0);
        check("annul_end result", bus.result_o, 64'd0);
        bus.annul_i = 1'b0; bus.start_i = 1'b0;

        // Annul in BY_ZERO: ready never rises.
        @(negedge clk);
        bus.start_i = 1'b1; bus.opdata1_i = 32'd9; bus.opdata2_i = 32'd0;
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(negedge clk);
        bus.annul_i = 1'b0; bus.start_i = 1'b0;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.ready_o) quiet = 1'b0;
        end
        check("annul_byzero no_ready", 64'(quiet), 64'd1);

        // Reset during ON: outputs clear, next divide takes full latency from IDLE.
        @(negedge clk);
        bus.start_i = 1'b1; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
        repeat (10) @(negedge clk);
        rst = 1'b1; bus.start_i = 1'b0;
        @(negedge clk);
        check("rst_on ready", 64'(bus.ready_o), 64'd0);
        check("rst_on result", bus.result_o, 64'd0);
        rst = 1'b0;
        run_div("after_rst", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle divider sequencer for the EX stage; owns the 32-iteration radix-2 restoring divide datapath for div/divu.
- Freezes the pipeline through stallreq_o until the quotient/remainder pair is ready, then hands the result to EX for the HI/LO write.
- Aborts cleanly on annul_i when the issuing instruction is killed (branch/exception flush).

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH. Only 32 is required to be supported.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- start_i  input  1  EX holds a div/divu; held high until the result is consumed.
- annul_i  input  1  cancel the in-flight divide.
- signed_div_i  input  1  1 = div (signed), 0 = divu.
- opdata1_i  input  32  dividend (rs).
- opdata2_i  input  32  divisor (rt).
- result_o  output  64  {remainder[63:32], quotient[31:0]}; registered.
- ready_o  output  1  result_o valid; registered.
- stallreq_o  output  1  stall request to the pipeline controller; combinational.

Behaviour:
- Reset (also mid-operation): state=IDLE, result_o=0, ready_o=0, cnt=0, internal dividend/divisor regs=0. Any divide in progress is lost.
- States: IDLE, BY_ZERO, ON, END; 2-bit encoding.
- IDLE, start_i=1 and annul_i=0:
  - opdata2_i==0 -> BY_ZERO.
  - Otherwise -> ON, cnt=0.
  - Operands are latched as magnitudes; a signed operand with bit31=1 is two's-complement negated first.
  - Latched: the two sign bits, the signed flag, the operands. Input changes after this edge are ignored.
- IDLE, otherwise: stay; ready_o=0, result_o=0.
- BY_ZERO: next edge -> END with result_o=64'h0. This defines divide-by-zero.
- ON, one restoring step per edge:
  - Shift {rem,quot} left by 1.
  - Trial = rem_hi - divisor, 33-bit subtract.
  - Non-negative -> rem_hi=trial, quotient bit=1; else quotient bit=0.
  - cnt increments.
  - On the edge that completes iteration 32, state -> END and result_o is loaded sign-corrected:
    - signed and dividend sign != divisor sign -> quotient negated.
    - signed and dividend negative -> remainder negated.
    - Unsigned -> no correction.
    - Corner case: -2^31 / -1 gives quotient 0x80000000 (wraps), remainder 0.
- annul_i=1 in ON or BY_ZERO: next edge -> IDLE, result_o=0, ready_o stays 0. In IDLE, annul_i blocks the start.
- END:
  - ready_o=1; result_o holds.
  - start_i=1 -> stay (pipeline still stalled downstream).
  - start_i=0 -> IDLE next edge; ready_o=0, result_o=0.
  - annul_i in END -> IDLE.
- stallreq_o = start_i & ~annul_i & (state != END).
- Latency from the first edge sampling start_i=1 in IDLE:
  - Nonzero divisor: ready_o is high after 33 edges (1 IDLE->ON, 32 iterations).
  - Divisor zero: ready_o is high after 2 edges.
- Back-to-back divides: start_i must drop for at least one cycle (END->IDLE) before the next start is accepted. start_i held high across END never restarts.

Test Plan:
- divu 100/7, start held -> ready_o rises after 33 edges, result_o=64'h00000002_0000000E. stallreq_o is 1 until END, then 0.
- div -7/2 (0xFFFFFFF9 / 2) -> result_o={32'hFFFFFFFF, 32'hFFFFFFFD}. div 7/-2 -> {32'h00000001, 32'hFFFFFFFD}.
- div 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. divu 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- Divisor 0 -> ready_o after 2 edges with result_o=0. Operands changed mid-ON -> result matches the latched operands.
- annul_i pulsed at iteration 10 -> stallreq_o drops that cycle, IDLE next edge, ready_o never rises. A new start then completes normally.
- Hold start_i 5 extra cycles in END -> result stable, ready_o=1. Drop start_i -> ready_o=0 and result_o=0 next edge. rst during ON -> all outputs 0, state IDLE.
